// File: rtl/serial_out_driver.sv
`default_nettype none
// ============================================================================
//  Module   : serial_out_driver
//  Purpose  : Parallel-in / serial-out driver for an external 74HC595-style
//             shift-register chain. A word accepted over valid/ready is
//             shifted out on sdo/sclk and then committed with one latch
//             pulse, so the chain outputs update atomically.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH          bits per frame (>= 2)
//    CLK_DIV        clk cycles per sclk half-period (>= 1)
//    MSB_FIRST      1: data_in[WIDTH-1] shifted first, 0: data_in[0] first
//    REFRESH_CYCLES idle cycles before an automatic retransmit
//  Ports
//    clk        in   system clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    data_in    in   parallel word to transmit
//    data_valid in   data_in valid
//    data_ready out  high only while idle
//    sdo        out  serial data to the chain
//    sclk       out  shift clock, chain samples sdo on its rising edge
//    latch      out  storage-register latch pulse, CLK_DIV cycles long
//    busy       out  high while shifting or latching
//  Configuration macro
//    AUTO_REFRESH_EN : retain the last word and retransmit it after
//                      REFRESH_CYCLES consecutive idle cycles.
// ============================================================================
module serial_out_driver #(
  parameter int WIDTH          = 22,
  parameter int CLK_DIV        = 4,
  parameter int MSB_FIRST      = 1,
  parameter int REFRESH_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sdo,
  output logic             sclk,
  output logic             latch,
  output logic             busy
);

  localparam int c_BW = $clog2(WIDTH);
  localparam int c_DW = $clog2(CLK_DIV) + 1;
  localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(WIDTH - 1);
  localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(CLK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;

  generate
    if (WIDTH < 2 || CLK_DIV < 1 || REFRESH_CYCLES < 1) begin : g_param_check
      $error("serial_out_driver: illegal parameter value");
    end
  endgenerate

  logic [1:0]       r_state, w_state_nxt;
  logic [c_DW-1:0]  r_div, w_div_nxt;
  logic [c_BW-1:0]  r_bit, w_bit_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic             r_sdo, w_sdo_nxt;
  logic             r_sclk, w_sclk_nxt;
  logic             r_latch, w_latch_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_ready, w_ready_nxt;

  logic             w_accept;
  logic             w_refresh;
  logic             w_start;
  logic [WIDTH-1:0] w_load;
  logic             w_div_last;
  logic             w_bit_last;

  // r_ready is high exactly while the FSM is in IDLE.
  assign w_accept   = r_ready & data_valid;
  assign w_start    = w_accept | w_refresh;
  assign w_div_last = (r_div == c_DIV_LAST);
  assign w_bit_last = (r_bit == c_BIT_LAST);

`ifdef AUTO_REFRESH_EN
  localparam int c_IW = $clog2(REFRESH_CYCLES) + 1;
  localparam logic [c_IW-1:0] c_IDLE_LAST = c_IW'(REFRESH_CYCLES - 1);

  logic [c_IW-1:0]  r_idle_cnt;
  logic [WIDTH-1:0] r_last;

  // A new word on the trigger cycle takes priority over the refresh.
  assign w_refresh = r_ready & ~data_valid & (r_idle_cnt == c_IDLE_LAST);
  assign w_load    = w_accept ? data_in : r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
      r_last     <= '0;
    end else begin
      if (w_accept) begin
        r_last <= data_in;
      end
      if (!r_ready || w_start) begin
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end
`else
  assign w_refresh = 1'b0;
  assign w_load    = data_in;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Leave only at the end of the last bit's high phase.
        if (w_div_last && r_sclk && w_bit_last) begin
          w_state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        if (w_div_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values; every output is registered below.
  always_comb begin
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_sdo_nxt   = r_sdo;
    w_sclk_nxt  = r_sclk;
    w_latch_nxt = r_latch;
    w_busy_nxt  = r_busy;
    w_ready_nxt = r_ready;
    case (r_state)
      S_IDLE: begin
        w_div_nxt = '0;
        w_bit_nxt = '0;
        if (w_start) begin
          w_shift_nxt = w_load;
          w_sdo_nxt   = (MSB_FIRST != 0) ? w_load[WIDTH-1] : w_load[0];
          w_sclk_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_ready_nxt = 1'b0;
        end
      end
      S_SHIFT: begin
        if (!w_div_last) begin
          w_div_nxt = r_div + 1'b1;
        end else begin
          w_div_nxt = '0;
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else begin
            // Falling sclk: the only point where sdo may move on.
            w_sclk_nxt = 1'b0;
            if (w_bit_last) begin
              w_latch_nxt = 1'b1;
            end else begin
              w_bit_nxt = r_bit + 1'b1;
              if (MSB_FIRST != 0) begin
                w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
                w_sdo_nxt   = r_shift[WIDTH-2];
              end else begin
                w_shift_nxt = {1'b0, r_shift[WIDTH-1:1]};
                w_sdo_nxt   = r_shift[1];
              end
            end
          end
        end
      end
      S_LATCH: begin
        if (!w_div_last) begin
          w_div_nxt = r_div + 1'b1;
        end else begin
          w_div_nxt   = '0;
          w_latch_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_div_nxt   = '0;
        w_bit_nxt   = '0;
        w_sdo_nxt   = 1'b0;
        w_sclk_nxt  = 1'b0;
        w_latch_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_sdo   <= 1'b0;
      r_sclk  <= 1'b0;
      r_latch <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_sdo   <= w_sdo_nxt;
      r_sclk  <= w_sclk_nxt;
      r_latch <= w_latch_nxt;
      r_busy  <= w_busy_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  assign data_ready = r_ready;
  assign sdo        = r_sdo;
  assign sclk       = r_sclk;
  assign latch      = r_latch;
  assign busy       = r_busy;

endmodule
`default_nettype wire
